// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline control types: FSM state, stage count
// and the stall/flush control bundle.
package pipeline_ctrl_pkg;

    localparam int unsigned NUM_STAGES = 5;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ERROR = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic id_ex_stall;
        logic ex_mem_stall;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE   = '0;
    localparam ctrl_t CTRL_RESET  = 7'b0000_111;
    localparam ctrl_t CTRL_FREEZE = 7'b1111_001;
    localparam ctrl_t CTRL_BRANCH = 7'b0000_110;
    localparam ctrl_t CTRL_LDUSE  = 7'b1100_010;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare between the EX load and
// the ID-stage source operands.
module hazard_detect (
    input  logic       id_valid,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       ex_valid,
    input  logic       ex_is_load,
    input  logic [4:0] ex_rd,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    // x0 never creates a dependency
    always_comb begin
        rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
        rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
        load_use = ex_valid && ex_is_load
                && (ex_rd != 5'd0) && id_valid
                && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller with memory-wait
// FSM, timeout error and stall-cycle counter.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_valid,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        id_ex_stall,
    output logic        ex_mem_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mem_wb_flush,
    output logic        error,
    output logic [31:0] stall_cycles
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]      stall_cnt_q, stall_cnt_d;
    logic             load_use;
    logic             freeze;
    ctrl_t            ctrl;

    hazard_detect u_hazard (
        .id_valid    (id_valid),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_valid    (ex_valid),
        .ex_is_load  (ex_is_load),
        .ex_rd       (ex_rd),
        .load_use    (load_use)
    );

    // State, wait counter and stall counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next state and counter updates
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (mem_req && !mem_ack) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_ack)               state_d = ST_RUN;
                else if (wait_cnt_q == TMO) state_d = ST_ERROR;
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_RUN;
        endcase

        wait_cnt_d = '0;
        if (state_q == ST_WAIT) begin
            wait_cnt_d = (wait_cnt_q == CNT_MAX)
                       ? wait_cnt_q : wait_cnt_q + 1'b1;
        end

        stall_cnt_d = stall_cnt_q;
        if (ctrl.pc_stall && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // Stall/flush mux: reset > freeze > branch > load-use
    always_comb begin
        freeze = ((state_q == ST_RUN) && mem_req && !mem_ack)
              || ((state_q == ST_WAIT) && !mem_ack)
              || (state_q == ST_ERROR);
        if (reset)                ctrl = CTRL_RESET;
        else if (freeze)          ctrl = CTRL_FREEZE;
        else if (ex_branch_taken) ctrl = CTRL_BRANCH;
        else if (load_use)        ctrl = CTRL_LDUSE;
        else                      ctrl = CTRL_NONE;
    end

    assign pc_stall     = ctrl.pc_stall;
    assign if_id_stall  = ctrl.if_id_stall;
    assign id_ex_stall  = ctrl.id_ex_stall;
    assign ex_mem_stall = ctrl.ex_mem_stall;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign mem_wb_flush = ctrl.mem_wb_flush;
    assign error        = (state_q == ST_ERROR);
    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (TIMEOUT=3) with
// an expected-output queue and a stall-count model.
module tb_pipeline_ctrl;

    localparam logic [6:0] E_NONE = 7'b0000_000;
    localparam logic [6:0] E_RST  = 7'b0000_111;
    localparam logic [6:0] E_FRZ  = 7'b1111_001;
    localparam logic [6:0] E_BR   = 7'b0000_110;
    localparam logic [6:0] E_LU   = 7'b1100_010;

    logic        clock = 1'b0;
    logic        reset;
    logic        id_valid, id_uses_rs1, id_uses_rs2;
    logic [4:0]  id_rs1, id_rs2;
    logic        ex_valid, ex_is_load;
    logic [4:0]  ex_rd;
    logic        ex_branch_taken;
    logic        mem_req, mem_ack;
    logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic        if_id_flush, id_ex_flush, mem_wb_flush;
    logic        error;
    logic [31:0] stall_cycles;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [6:0]  exp_q[$];
    logic [31:0] model_stalls = 0;

    always #5 clock = ~clock;

    pipeline_ctrl #(.TIMEOUT(3), .CNT_W(8)) dut (
        .clock           (clock),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .ex_valid        (ex_valid),
        .ex_is_load      (ex_is_load),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ack         (mem_ack),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .id_ex_stall     (id_ex_stall),
        .ex_mem_stall    (ex_mem_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .mem_wb_flush    (mem_wb_flush),
        .error           (error),
        .stall_cycles    (stall_cycles)
    );

    task automatic idle();
        id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_rs1 = 0; id_rs2 = 0;
        ex_valid = 0; ex_is_load = 0; ex_rd = 0;
        ex_branch_taken = 0; mem_req = 0; mem_ack = 0;
    endtask

    task automatic set_load(input logic [4:0] rd);
        ex_valid = 1; ex_is_load = 1; ex_rd = rd;
        id_valid = 1;
    endtask

    // Push expectation, sample mid-cycle, compare, advance one cycle
    task automatic step(input string tag, input logic [6:0] e);
        logic [6:0] got, want;
        exp_q.push_back(e);
        if (e[6] && !reset) model_stalls = model_stalls + 1;
        if (reset) model_stalls = 0;
        #1;
        got = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
               if_id_flush, id_ex_flush, mem_wb_flush};
        want = exp_q.pop_front();
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s ctrl got=%b exp=%b", tag, got, want);
        end
        @(negedge clock);
    endtask

    task automatic chk_cnt(input string tag);
        n_assert++;
        assert (stall_cycles === model_stalls) else begin
            n_fail++;
            $error("FAIL %s stall_cycles got=%0d exp=%0d",
                   tag, stall_cycles, model_stalls);
        end
    endtask

    task automatic chk_err(input string tag, input logic e);
        n_assert++;
        assert (error === e) else begin
            n_fail++;
            $error("FAIL %s error got=%b exp=%b", tag, error, e);
        end
    endtask

    initial begin
        idle();
        reset = 1;
        @(negedge clock);
        step("reset_hold0", E_RST);
        step("reset_hold1", E_RST);
        chk_cnt("reset_cnt");
        chk_err("reset_err", 1'b0);

        reset = 0;
        step("idle", E_NONE);

        set_load(5'd5); id_uses_rs1 = 1; id_rs1 = 5'd5;
        step("ldu_rs1", E_LU);
        idle();
        step("ldu_after", E_NONE);
        chk_cnt("ldu_cnt");

        set_load(5'd0); id_uses_rs1 = 1; id_rs1 = 5'd0;
        step("x0_nostall", E_NONE);

        set_load(5'd7); id_uses_rs1 = 1; id_rs1 = 5'd3;
        id_uses_rs2 = 0; id_rs2 = 5'd7;
        step("rs2_unused", E_NONE);

        id_uses_rs2 = 1;
        step("ldu_rs2", E_LU);
        chk_cnt("ldu2_cnt");

        ex_branch_taken = 1;
        step("br_over_ldu", E_BR);
        chk_cnt("br_cnt");

        idle();
        reset = 1;
        step("reset_mid", E_RST);
        reset = 0;

        mem_req = 1; ex_branch_taken = 1;
        for (int i = 1; i <= 3; i++) step($sformatf("frz_br%0d", i), E_FRZ);
        mem_ack = 1;
        step("frz_br_ack", E_BR);
        chk_cnt("frz_cnt3");
        n_assert++;
        assert (stall_cycles === 32'd3) else begin
            n_fail++;
            $error("FAIL frz_cnt_abs got=%0d exp=3", stall_cycles);
        end

        idle();
        mem_req = 1; mem_ack = 1;
        step("zero_wait", E_NONE);
        mem_req = 0; mem_ack = 0;
        step("zero_wait_run", E_NONE);

        mem_req = 1;
        step("to_run_frz", E_FRZ);
        for (int i = 0; i <= 3; i++) begin
            chk_err($sformatf("wait%0d_err", i), 1'b0);
            step($sformatf("wait%0d", i), E_FRZ);
        end
        chk_err("timeout_err", 1'b1);
        mem_ack = 1;
        step("error_frz", E_FRZ);
        chk_err("error_sticky", 1'b1);
        chk_cnt("error_cnt");

        reset = 1;
        step("err_reset", E_RST);
        reset = 0;
        idle();
        chk_err("post_reset_err", 1'b0);
        chk_cnt("post_reset_cnt");
        step("post_reset_run", E_NONE);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
